// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution datapath
// (conv_buffer, conv_mac_pipe, pooling stage).
//   clog2      : ceil(log2(n)), usable in parameter expressions
//   ntap       : taps in a FILTER_SIZE x FILTER_SIZE window
//   acc_bits   : full-precision accumulator width of the MAC tree
//   bias_addr  : cfg address of the bias register (first address after the weights)
//   saturate   : clamp a signed value to a signed 'bits'-wide range
package conv_pkg;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ntap(input int fs);
    return fs * fs;
  endfunction

  function automatic int acc_bits(input int db, input int wb, input int fs);
    return db + wb + 1 + clog2(fs * fs);
  endfunction

  function automatic int bias_addr(input int fs);
    return fs * fs;
  endfunction

  localparam int BIAS_ADDR = 25;  // default 5x5 kernel

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_pipe_if.sv
// Window / coefficient / result bundle between conv_buffer, conv_mac_pipe
// and the pooling stage.
//   master : producer side (drives window + cfg, receives result)
//   slave  : conv_mac_pipe side
//   in_val, data_in          window strobe and NTAP*DATA_BITS packed window
//   cfg_we, cfg_addr, cfg_data  coefficient write port
//   data_out, valid, busy    signed result, result strobe, pipeline occupancy
interface conv_mac_pipe_if #(
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 5,
  parameter int BIAS_BITS   = 16,
  parameter int OUT_BITS    = 12
);
  localparam int NTAP = FILTER_SIZE * FILTER_SIZE;
  localparam int AW   = conv_pkg::clog2(NTAP + 1);

  logic                       in_val;
  logic [NTAP*DATA_BITS-1:0]  data_in;
  logic                       cfg_we;
  logic [AW-1:0]              cfg_addr;
  logic [BIAS_BITS-1:0]       cfg_data;
  logic signed [OUT_BITS-1:0] data_out;
  logic                       valid;
  logic                       busy;

  modport master (output in_val, data_in, cfg_we, cfg_addr, cfg_data,
                  input  data_out, valid, busy);
  modport slave  (input  in_val, data_in, cfg_we, cfg_addr, cfg_data,
                  output data_out, valid, busy);
endinterface

// File: rtl/conv_adder_tree.sv
// Generic pipelined signed reduction: N inputs summed pairwise, one
// register per level, odd element of a level forwarded through a register.
//   clk, rst_n  : clock, async active-low reset (valid pipeline only)
//   in_vld, din : input strobe and N signed IN_BITS operands
//   out_vld     : strobe aligned with dout (LVLS cycles after in_vld)
//   stage_vld   : per-level valid bits, for occupancy reporting
//   dout        : full-precision sum, IN_BITS+clog2(N) bits
// Every level is held at the final width; values are sign-extended so the
// result equals the 1-bit-per-level widened sum and cannot overflow.
module conv_adder_tree import conv_pkg::*; #(
  parameter  int N        = 25,
  parameter  int IN_BITS  = 17,
  localparam int LVLS     = clog2(N),
  localparam int OUT_BITS = IN_BITS + LVLS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic signed [IN_BITS-1:0]  din [N],
  output logic                       out_vld,
  output logic [LVLS:1]              stage_vld,
  output logic signed [OUT_BITS-1:0] dout
);
  function automatic int lvl_cnt(input int l);
    int c = N;
    for (int i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction

  logic signed [OUT_BITS-1:0] lvl0 [N];
  logic signed [OUT_BITS-1:0] lvl  [1:LVLS][N];
  logic [LVLS:1]              vld_pipe;

  always_comb
    for (int i = 0; i < N; i++) lvl0[i] = OUT_BITS'(din[i]);

  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    localparam int NI = lvl_cnt(l - 1);
    logic signed [OUT_BITS-1:0] src [N];

    if (l == 1) begin : g_first
      always_comb for (int i = 0; i < N; i++) src[i] = lvl0[i];
    end else begin : g_next
      always_comb for (int i = 0; i < N; i++) src[i] = lvl[l-1][i];
    end

    for (genvar i = 0; i < N; i++) begin : g_node
      if (2*i + 1 < NI) begin : g_add
        always_ff @(posedge clk) lvl[l][i] <= src[2*i] + src[2*i+1];
      end else if (2*i < NI) begin : g_pass
        always_ff @(posedge clk) lvl[l][i] <= src[2*i];
      end else begin : g_zero
        always_ff @(posedge clk) lvl[l][i] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[LVLS-1:1], in_vld};

  assign out_vld   = vld_pipe[LVLS];
  assign stage_vld = vld_pipe;
  assign dout      = lvl[LVLS][0];
endmodule

// File: rtl/conv_mac_pipe.sv
// Convolution MAC: multiplies each FILTER_SIZE^2 window by a programmable
// signed kernel, reduces in a pipelined tree, adds bias, shifts right
// (floor) and saturates to one signed sample per window. 7-cycle fixed
// latency, one window per clock, no backpressure.
//   clk, rst_n : clock, async active-low reset
//   bus        : conv_mac_pipe_if.slave (window in, cfg writes, result out)
// Build option: CONV_MAC_RELU_EN clamps negative results to 0 at the
// output stage (latency unchanged).
module conv_mac_pipe import conv_pkg::*; #(
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 5,
  parameter int WEIGHT_BITS = 8,
  parameter int BIAS_BITS   = 16,
  parameter int SHIFT       = 4,
  parameter int OUT_BITS    = 12
) (
  input logic           clk,
  input logic           rst_n,
  conv_mac_pipe_if.slave bus
);
  localparam int NTAP     = ntap(FILTER_SIZE);
  localparam int PW       = DATA_BITS + WEIGHT_BITS + 1;
  localparam int ACC_BITS = acc_bits(DATA_BITS, WEIGHT_BITS, FILTER_SIZE);
  localparam int LVLS     = clog2(NTAP);

  logic signed [WEIGHT_BITS-1:0] w [NTAP];
  logic signed [BIAS_BITS-1:0]   bias;
  logic signed [PW-1:0]          prod [NTAP];
  logic                          vld1;
  logic signed [ACC_BITS-1:0]    acc;
  logic                          acc_vld;
  logic [LVLS:1]                 tree_vld;
  logic signed [63:0]            biased;
  logic signed [OUT_BITS-1:0]    sat_raw;
  logic signed [OUT_BITS-1:0]    sat_v;
  logic signed [OUT_BITS-1:0]    out_q;
  logic                          vld_q;

  // Coefficients. Nonblocking update means a window sampled on the write
  // edge still multiplies by the previous weight.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NTAP; k++) w[k] <= '0;
      bias <= '0;
    end else if (bus.cfg_we) begin
      if (int'(bus.cfg_addr) < NTAP)
        w[bus.cfg_addr] <= bus.cfg_data[WEIGHT_BITS-1:0];
      else if (int'(bus.cfg_addr) == bias_addr(FILTER_SIZE))
        bias <= bus.cfg_data;
    end

  // Stage 1: pixels are unsigned, so a zero bit is prepended before the
  // signed multiply.
  always_ff @(posedge clk)
    if (bus.in_val)
      for (int k = 0; k < NTAP; k++)
        prod[k] <= PW'($signed({1'b0, bus.data_in[k*DATA_BITS +: DATA_BITS]})) * PW'(w[k]);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld1 <= 1'b0;
    else        vld1 <= bus.in_val;

  // Stages 2..6
  conv_adder_tree #(.N(NTAP), .IN_BITS(PW)) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (vld1),
    .din       (prod),
    .out_vld   (acc_vld),
    .stage_vld (tree_vld),
    .dout      (acc)
  );

  // Stage 7: bias, floor shift (>>> on signed), saturate, optional ReLU.
  always_comb begin
    biased  = 64'(acc) + 64'(bias);
    sat_raw = OUT_BITS'(saturate(biased >>> SHIFT, OUT_BITS));
`ifdef CONV_MAC_RELU_EN
    sat_v   = (sat_raw < 0) ? '0 : sat_raw;
`else
    sat_v   = sat_raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= acc_vld;
      if (acc_vld) out_q <= sat_v;
    end

  assign bus.data_out = out_q;
  assign bus.valid    = vld_q;
  assign bus.busy     = vld1 | (|tree_vld) | vld_q;
endmodule

// File: tb/tb_conv_mac_pipe.sv
// Bench for conv_mac_pipe: directed kernels plus a random 28x28 image
// swept as 24x24 windows with random gaps, against a sum-of-products model.
module tb_conv_mac_pipe;
  localparam int DB = 8, FS = 5, WB = 8, BB = 16, SH = 4, OB = 12;
  localparam int NT = FS * FS, AW = 5, LAT = 7;
  localparam longint OMAX = (64'sd1 <<< (OB - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OB - 1));

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_mac_pipe_if #(.DATA_BITS(DB), .FILTER_SIZE(FS), .BIAS_BITS(BB), .OUT_BITS(OB)) bus ();

  conv_mac_pipe #(.DATA_BITS(DB), .FILTER_SIZE(FS), .WEIGHT_BITS(WB),
                  .BIAS_BITS(BB), .SHIFT(SH), .OUT_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { bit v; longint d; } exp_t;

  int     m_w [NT];
  int     m_bias;
  int     pix [NT];
  int     img [28][28];
  exp_t   pipe_q [$];
  longint held;
  int     n_chk, n_err, n_obs;

  function automatic longint ref_out();
    longint s = longint'(m_bias);
    longint q;
    for (int k = 0; k < NT; k++) s += longint'(pix[k]) * longint'(m_w[k]);
    q = s / (64'sd1 <<< SH);
    if (s < 0 && q * (64'sd1 <<< SH) != s) q -= 1;
    if (q > OMAX) q = OMAX;
    if (q < OMIN) q = OMIN;
`ifdef CONV_MAC_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_win();
    for (int k = 0; k < NT; k++) bus.data_in[k*DB +: DB] = DB'(pix[k]);
  endtask

  task automatic set_pix_all(input int v);
    for (int k = 0; k < NT; k++) pix[k] = v;
    load_win();
  endtask

  // One clock: model the edge, then compare all outputs 1 ns later.
  task automatic step();
    exp_t e, o;
    bit   b;
    @(posedge clk);
    e.v = bus.in_val;
    e.d = bus.in_val ? ref_out() : 0;
    if (bus.cfg_we) begin
      if (bus.cfg_addr < NT)       m_w[bus.cfg_addr] = $signed(bus.cfg_data[WB-1:0]);
      else if (bus.cfg_addr == NT) m_bias = $signed(bus.cfg_data);
    end
    pipe_q.push_back(e);
    #1;
    b = 1'b0;
    foreach (pipe_q[i]) b |= pipe_q[i].v;
    o.v = 1'b0; o.d = 0;
    if (pipe_q.size() == LAT) o = pipe_q.pop_front();
    if (o.v) held = o.d;
    if (bus.valid) n_obs++;
    chk("valid", longint'(bus.valid), longint'(o.v));
    chk("data_out", longint'(bus.data_out), held);
    chk("busy", longint'(bus.busy), longint'(b));
  endtask

  task automatic cfg(input int addr, input int data);
    bus.cfg_we = 1'b1; bus.cfg_addr = AW'(addr); bus.cfg_data = BB'(data);
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic set_all_w(input int v);
    for (int k = 0; k < NT; k++) cfg(k, v);
  endtask

  task automatic drain();
    bus.in_val = 1'b0;
    repeat (LAT + 1) step();
  endtask

  task automatic one_window();
    bus.in_val = 1'b1;
    step();
    drain();
  endtask

  // Entered just after a rising edge; asserts reset between edges, holds it
  // across 'edges' rising edges, releases 3 ns after the last one.
  task automatic do_reset(input int edges);
    #3 rst_n = 1'b0;
    #1;
    pipe_q.delete(); held = 0; m_bias = 0;
    for (int k = 0; k < NT; k++) m_w[k] = 0;
    chk("rst_data_out", longint'(bus.data_out), 0);
    chk("rst_valid", longint'(bus.valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    repeat (edges) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_obs = 0; held = 0; m_bias = 0;
    for (int k = 0; k < NT; k++) begin m_w[k] = 0; pix[k] = 0; end
    rst_n = 1'b1;
    bus.in_val = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;

    // 1: async reset mid-cycle
    do_reset(2);

    // 2: all ones -> 25>>>4 = 1
    set_all_w(1); cfg(NT, 0);
    set_pix_all(1);
    one_window();
    chk("t2_ones", longint'(bus.data_out), 1);

    // weight write on the same edge as a window: old weight for it, new after
    bus.cfg_we = 1'b1; bus.cfg_addr = AW'(0); bus.cfg_data = BB'(100);
    bus.in_val = 1'b1;
    step();
    bus.cfg_we = 1'b0;
    step();
    drain();
    chk("t2_new_w", longint'(bus.data_out), 7);

    // out-of-range address is ignored
    cfg(31, 16'h7fff);
    one_window();
    chk("t2_bad_addr", longint'(bus.data_out), 7);

    // 3: centre tap only
    for (int k = 0; k < NT; k++) cfg(k, (k == 12) ? 16 : 0);
    set_pix_all(0); pix[12] = 255; load_win();
    one_window();
    chk("t3_centre", longint'(bus.data_out), 255);

    // 4: saturation both ways
    set_all_w(127); set_pix_all(255);
    one_window();
    chk("t4_sat_hi", longint'(bus.data_out), 2047);
    set_all_w(-128);
    one_window();
`ifdef CONV_MAC_RELU_EN
    chk("t4_sat_lo", longint'(bus.data_out), 0);
`else
    chk("t4_sat_lo", longint'(bus.data_out), -2048);
`endif

    // 5: floor rounding of a negative sum
    set_all_w(1); cfg(NT, -32); set_pix_all(1);
    one_window();
`ifdef CONV_MAC_RELU_EN
    chk("t5_floor", longint'(bus.data_out), 0);
`else
    chk("t5_floor", longint'(bus.data_out), -1);
`endif

    // 6: random kernel, 28x28 image, 576 windows with random gaps
    for (int k = 0; k < NT; k++) cfg(k, int'($urandom_range(0, 31)) - 16);
    cfg(NT, int'($urandom_range(0, 4000)) - 2000);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) img[r][c] = int'($urandom_range(0, 255));
    n_obs = 0;
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.in_val = 1'b0;
          repeat ($urandom_range(1, 3)) step();
        end
        for (int k = 0; k < NT; k++) pix[k] = img[r + k / FS][c + k % FS];
        load_win();
        bus.in_val = 1'b1;
        step();
      end
    bus.in_val = 1'b0;
    repeat (LAT - 1) step();
    chk("t6_busy_held", longint'(bus.busy), 1);
    step();
    chk("t6_busy_fall", longint'(bus.busy), 0);
    chk("t6_count", longint'(n_obs), 576);

    // 7: reset with 3 windows in flight, in_val held high through reset
    set_pix_all(200);
    bus.in_val = 1'b1;
    repeat (3) step();
    do_reset(1);
    bus.in_val = 1'b0;
    n_obs = 0;
    repeat (10) step();
    chk("t7_no_pulse", longint'(n_obs), 0);
    set_pix_all(255);
    one_window();
    chk("t7_one_pulse", longint'(n_obs), 1);
    chk("t7_zero_w", longint'(bus.data_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
